multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr  input  32  RV32I instruction word, sampled when instr_valid and instr_ready are both high.
REQ-005 SHALL have port instr_valid / instr_ready  input / output  1 / 1  fetch handshake.
REQ-006 SHALL have port alu_zero / alu_lsb  input / input  1 / 1  ALU result ==0 and ALU result bit 0, used for branch decisions.
REQ-007 SHALL have port mem_ack  input  1  data-memory completion.
REQ-008 SHALL have port alu_op  output  4  ALU operation code.
REQ-009 SHALL have ports a_sel (0=rs1, 1=PC) and b_sel (0=rs2, 1=immediate), each output, 1 bit.
REQ-010 SHALL have ports reg_we, mem_req, mem_we, pc_we, pc_branch, illegal, each output, 1 bit.
REQ-011 SHALL have port retired  output  RETIRE_W  count of completed instructions.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- FETCH: instr_ready=1; on handshake latch instr, go to DECODE; otherwise stay.
- DECODE: one cycle; go to EXECUTE, or to TRAP if the opcode is illegal.
- EXECUTE: one cycle; loads/stores go to MEMORY, branches go to FETCH, all others go to WRITEBACK.
- MEMORY: mem_req=1 and mem_we=store, held until mem_ack; then loads go to WRITEBACK, stores go to FETCH.
- WRITEBACK: reg_we=1 for one cycle; go to FETCH.
REQ-013 SHALL drive alu_op from the latched instruction in EXECUTE, using these codes:
- 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 1111 pass-B.
REQ-014 SHALL select alu_op by instruction class:
- R-type (0110011): alu_op = {funct7[5], funct3}.
- OP-IMM (0010011): alu_op = {funct3==101 ? funct7[5] : 0, funct3}.
- LUI: 1111.
- LOAD, STORE, AUIPC, JAL, JALR: 0000.
- BEQ/BNE: 1000.
- BLT/BGE: 0010.
- BLTU/BGEU: 0011.
REQ-015 SHALL, in EXECUTE, set a_sel=1 for AUIPC and JAL, and b_sel=1 for all classes except R-type and branch.
REQ-016 SHALL take a branch for BEQ when alu_zero=1, BNE when alu_zero=0, BLT/BLTU when alu_lsb=1, and BGE/BGEU when alu_lsb=0.
REQ-017 SHALL pulse pc_we for one cycle in EXECUTE for every branch, JAL and JALR, with pc_branch=1 only for taken branches and jumps.
REQ-018 SHALL pulse pc_we (sequential PC) in WRITEBACK for non-jump instructions, and in the last cycle before FETCH for stores and not-taken branches.
REQ-019 SHALL treat as illegal any opcode outside the RV32I classes of REQ-014, and any R-type with funct7 not in {0000000, 0100000}.
REQ-020 SHALL increment retired by 1 on each transition into FETCH from a non-reset state, wrapping modulo 2^RETIRE_W.
REQ-021 SHALL hold all outputs except alu_op at 0 outside the states that assert them; alu_op SHALL be 0000 outside EXECUTE.
REQ-022 SHALL keep mem_req high across any mem_ack-low wait with no timeout, and SHALL ignore mem_ack outside MEMORY.

Reset
REQ-023 SHALL, on rst_n low, immediately enter FETCH, clear retired and the latched instruction, and drive all outputs to 0 except instr_ready=0 until the first clock edge after rst_n deasserts.
REQ-024 SHALL abandon an in-flight instruction when reset occurs mid-MEMORY, with no reg_we or retired increment for it.

Configuration
REQ-025 SHALL honour macro ILLEGAL_TRAP_EN:
- Defined: illegal instructions enter TRAP, which holds illegal=1, instr_ready=0 and all write enables 0 until reset.
- Undefined: TRAP is not built; illegal instructions pulse illegal for one cycle in DECODE and are retired as NOP (pc_we sequential, no reg_we), returning to FETCH.

Verification
REQ-026 SHALL cover: ADD x3,x1,x2 (0x002081B3) -> alu_op=0000, b_sel=0, reg_we one cycle in WRITEBACK, retired 0->1, 4 cycles from handshake to FETCH.
REQ-027 SHALL cover: SRAI x5,x5,3 (0x4032D293) -> alu_op=1101, b_sel=1.
REQ-028 SHALL cover: LW with mem_ack delayed 5 cycles -> mem_req high exactly 6 cycles, reg_we after ack.
REQ-029 SHALL cover: BNE with alu_zero=0 -> pc_we=1, pc_branch=1 in EXECUTE, no reg_we; repeat with alu_zero=1 -> pc_branch=0.
REQ-030 SHALL cover: opcode 0x0000007F -> with ILLEGAL_TRAP_EN, illegal stays 1 and instr_ready stays 0 for 20 cycles; without it, a one-cycle illegal pulse and retired+1.
REQ-031 SHALL cover: rst_n low mid-MEMORY -> outputs 0 asynchronously, retired=0, FETCH after release.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Control FSM for a multicycle RV32I datapath. Each instruction passes
//   through FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] -> FETCH.
//   Datapath controls are decoded from the instruction latched at the fetch
//   handshake.
//
// Configuration macro: ILLEGAL_TRAP_EN
//   defined   : an illegal instruction enters TRAP and stays there until reset
//               (illegal=1, instr_ready=0, all write enables 0).
//   undefined : an illegal instruction pulses illegal in DECODE, advances the
//               PC sequentially and is retired as a NOP.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   instr               RV32I instruction word, latched on valid && ready
//   instr_valid/_ready  fetch handshake
//   alu_zero, alu_lsb   ALU result == 0 and ALU result bit 0 (branch decisions)
//   mem_ack             data-memory completion (observed in MEMORY only)
//   alu_op              ALU operation code (0000 outside EXECUTE)
//   a_sel, b_sel        ALU operand selects (a: 0=rs1 1=PC, b: 0=rs2 1=imm)
//   reg_we              register-file write enable (WRITEBACK)
//   mem_req, mem_we     data-memory request / write (MEMORY)
//   pc_we, pc_branch    PC write and branch/jump target select
//   illegal             illegal-instruction indication
//   retired             count of completed instructions (wraps)
module multicycle_control #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                alu_zero,
    input  logic                alu_lsb,
    input  logic                mem_ack,
    output logic [3:0]          alu_op,
    output logic                a_sel,
    output logic                b_sel,
    output logic                reg_we,
    output logic                mem_req,
    output logic                mem_we,
    output logic                pc_we,
    output logic                pc_branch,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
`ifdef ILLEGAL_TRAP_EN
        TRAP      = 3'd5,
`endif
        WRITEBACK = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           instr_q, instr_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;
    // Holds instr_ready low until the first clock edge after reset release.
    logic                  ready_en_q;

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr;
    logic       is_branch, is_load, is_store;
    logic       instr_illegal;
    logic       br_taken;
    logic       handshake;
    logic       unused_bits;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    // Register and immediate fields are consumed by the datapath, not here.
    assign unused_bits = ^{instr_q[24:15], instr_q[11:7]};

    assign is_op     = (opcode == 7'b0110011);
    assign is_opimm  = (opcode == 7'b0010011);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_auipc  = (opcode == 7'b0010111);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_branch = (opcode == 7'b1100011);
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);

    assign instr_illegal =
        !(is_op || is_opimm || is_lui || is_auipc || is_jal || is_jalr ||
          is_branch || is_load || is_store) ||
        (is_op && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));

    always_comb begin
        br_taken = 1'b0;
        unique case (funct3)
            3'b000:         br_taken = alu_zero;   // BEQ
            3'b001:         br_taken = !alu_zero;  // BNE
            3'b100, 3'b110: br_taken = alu_lsb;    // BLT / BLTU
            3'b101, 3'b111: br_taken = !alu_lsb;   // BGE / BGEU
            default:        br_taken = 1'b0;
        endcase
    end

    assign handshake = instr_valid && instr_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            instr_q    <= '0;
            retired_q  <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
            ready_en_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        unique case (state_q)
            FETCH: begin
                if (handshake) begin
                    instr_d = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (instr_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = TRAP;
`else
                    state_d = FETCH;
`endif
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (is_load || is_store) state_d = MEMORY;
                else if (is_branch)      state_d = FETCH;
                else                     state_d = WRITEBACK;
            end
            MEMORY: begin
                if (mem_ack) state_d = is_load ? WRITEBACK : FETCH;
            end
            WRITEBACK: state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
            TRAP:      state_d = TRAP;
`endif
            default:   state_d = FETCH;
        endcase
    end

    // Every arrival in FETCH from another state completes one instruction.
    always_comb begin
        retired_d = retired_q;
        if ((state_d == FETCH) && (state_q != FETCH))
            retired_d = retired_q + RETIRE_W'(1);
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready = 1'b0;
        alu_op      = 4'b0000;
        a_sel       = 1'b0;
        b_sel       = 1'b0;
        reg_we      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        pc_we       = 1'b0;
        pc_branch   = 1'b0;
        illegal     = 1'b0;
        unique case (state_q)
            FETCH: instr_ready = ready_en_q;
            DECODE: begin
`ifndef ILLEGAL_TRAP_EN
                // Illegal instruction retires as a NOP: sequential PC, no write.
                illegal = instr_illegal;
                pc_we   = instr_illegal;
`endif
            end
            EXECUTE: begin
                if (is_op) begin
                    alu_op = {funct7[5], funct3};
                end else if (is_opimm) begin
                    alu_op = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                end else if (is_lui) begin
                    alu_op = 4'b1111;
                end else if (is_branch) begin
                    unique case (funct3)
                        3'b100, 3'b101: alu_op = 4'b0010;
                        3'b110, 3'b111: alu_op = 4'b0011;
                        default:        alu_op = 4'b1000;
                    endcase
                end else begin
                    alu_op = 4'b0000;
                end
                a_sel     = is_auipc || is_jal;
                b_sel     = !(is_op || is_branch);
                pc_we     = is_branch || is_jal || is_jalr;
                pc_branch = (is_branch && br_taken) || is_jal || is_jalr;
            end
            MEMORY: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                // A store finishes here, so the sequential PC update happens here.
                pc_we   = is_store && mem_ack;
            end
            WRITEBACK: begin
                reg_we = 1'b1;
                pc_we  = !(is_jal || is_jalr);
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Output vector layout used in the
// comparisons: {instr_ready, alu_op[3:0], a_sel, b_sel, reg_we, mem_req,
// mem_we, pc_we, pc_branch, illegal}.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        alu_zero;
    logic        alu_lsb;
    logic        mem_ack;
    logic [3:0]  alu_op;
    logic        a_sel, b_sel, reg_we, mem_req, mem_we, pc_we, pc_branch, illegal;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    localparam logic [12:0] IDLE = 13'b1_0000_00_000_000;
    localparam logic [12:0] WB_SEQ = 13'b0_0000_00_100_100;

    multicycle_control #(.RETIRE_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_zero(alu_zero), .alu_lsb(alu_lsb),
        .mem_ack(mem_ack), .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel),
        .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we),
        .pc_branch(pc_branch), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] outs();
        return {instr_ready, alu_op, a_sel, b_sel, reg_we, mem_req, mem_we,
                pc_we, pc_branch, illegal};
    endfunction

    // Offer one instruction; returns at the negedge after the handshake (DECODE).
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_timeout: instr_ready=%b required 1", instr_ready);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        instr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs() !== 13'd0) begin
            errors++; $display("FAIL reset_outs: got %b want %b", outs(), 13'd0);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++; $display("FAIL reset_retired: got %0d want 0", retired);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_hold: got %b want 0", instr_ready);
        end
        @(negedge clk);
        checks++;
        if (outs() !== IDLE) begin
            errors++; $display("FAIL reset_fetch: got %b want %b", outs(), IDLE);
        end
    endtask

    task automatic test_add();
        send(32'h002081B3);
        checks++;
        if (outs() !== 13'd0) begin
            errors++; $display("FAIL add_decode: got %b want %b", outs(), 13'd0);
        end
        @(negedge clk);
        checks++;
        if (outs() !== 13'b0_0000_00_000_000) begin
            errors++; $display("FAIL add_exec: got %b want %b", outs(), 13'b0);
        end
        @(negedge clk);
        checks++;
        if (outs() !== WB_SEQ) begin
            errors++; $display("FAIL add_wb: got %b want %b", outs(), WB_SEQ);
        end
        @(negedge clk);
        checks++;
        if (outs() !== IDLE || retired !== 32'd1) begin
            errors++; $display("FAIL add_fetch: got %b/%0d want %b/1", outs(), retired, IDLE);
        end
    endtask

    task automatic test_srai();
        send(32'h4032D293);
        @(negedge clk);
        checks++;
        if (outs() !== 13'b0_1101_01_000_000) begin
            errors++; $display("FAIL srai_exec: got %b want %b", outs(), 13'b0_1101_01_000_000);
        end
        @(negedge clk);
        checks++;
        if (outs() !== WB_SEQ) begin
            errors++; $display("FAIL srai_wb: got %b want %b", outs(), WB_SEQ);
        end
        @(negedge clk);
        checks++;
        if (retired !== 32'd2) begin
            errors++; $display("FAIL srai_retired: got %0d want 2", retired);
        end
    endtask

    task automatic test_load_wait();
        send(32'h00012083);
        @(negedge clk);
        checks++;
        if (outs() !== 13'b0_0000_01_000_000) begin
            errors++; $display("FAIL lw_exec: got %b want %b", outs(), 13'b0_0000_01_000_000);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 13'b0_0000_00_010_000) begin
                errors++; $display("FAIL lw_mem_cycle%0d: got %b want %b", k, outs(), 13'b0_0000_00_010_000);
            end
            if (k == 5) mem_ack = 1'b1;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (outs() !== WB_SEQ) begin
            errors++; $display("FAIL lw_wb: got %b want %b", outs(), WB_SEQ);
        end
        @(negedge clk);
        checks++;
        if (outs() !== IDLE || retired !== 32'd3) begin
            errors++; $display("FAIL lw_fetch: got %b/%0d want %b/3", outs(), retired, IDLE);
        end
    endtask

    task automatic test_store();
        send(32'h0020A023);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (outs() !== 13'b0_0000_00_011_000) begin
            errors++; $display("FAIL sw_mem: got %b want %b", outs(), 13'b0_0000_00_011_000);
        end
        mem_ack = 1'b1;
        #1;
        checks++;
        if (outs() !== 13'b0_0000_00_011_100) begin
            errors++; $display("FAIL sw_ack: got %b want %b", outs(), 13'b0_0000_00_011_100);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (outs() !== IDLE || retired !== 32'd4) begin
            errors++; $display("FAIL sw_fetch: got %b/%0d want %b/4", outs(), retired, IDLE);
        end
    endtask

    // mem_ack is held high throughout to show it has no effect outside MEMORY.
    task automatic test_branch();
        mem_ack = 1'b1;
        alu_zero = 1'b0;
        send(32'h00209063);
        @(negedge clk);
        checks++;
        if (outs() !== 13'b0_1000_00_000_110) begin
            errors++; $display("FAIL bne_taken: got %b want %b", outs(), 13'b0_1000_00_000_110);
        end
        @(negedge clk);
        checks++;
        if (outs() !== IDLE || retired !== 32'd5) begin
            errors++; $display("FAIL bne_taken_fetch: got %b/%0d want %b/5", outs(), retired, IDLE);
        end
        alu_zero = 1'b1;
        send(32'h00209063);
        @(negedge clk);
        checks++;
        if (outs() !== 13'b0_1000_00_000_100) begin
            errors++; $display("FAIL bne_not_taken: got %b want %b", outs(), 13'b0_1000_00_000_100);
        end
        @(negedge clk);
        checks++;
        if (outs() !== IDLE || retired !== 32'd6) begin
            errors++; $display("FAIL bne_nt_fetch: got %b/%0d want %b/6", outs(), retired, IDLE);
        end
        mem_ack = 1'b0;
        alu_zero = 1'b0;
    endtask

    task automatic test_jump_lui();
        send(32'h000000EF);
        @(negedge clk);
        checks++;
        if (outs() !== 13'b0_0000_11_000_110) begin
            errors++; $display("FAIL jal_exec: got %b want %b", outs(), 13'b0_0000_11_000_110);
        end
        @(negedge clk);
        checks++;
        if (outs() !== 13'b0_0000_00_100_000) begin
            errors++; $display("FAIL jal_wb: got %b want %b", outs(), 13'b0_0000_00_100_000);
        end
        @(negedge clk);
        send(32'h123450B7);
        @(negedge clk);
        checks++;
        if (outs() !== 13'b0_1111_01_000_000) begin
            errors++; $display("FAIL lui_exec: got %b want %b", outs(), 13'b0_1111_01_000_000);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (retired !== 32'd8) begin
            errors++; $display("FAIL lui_retired: got %0d want 8", retired);
        end
    endtask

    task automatic test_reset_mid_memory();
        send(32'h00012083);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (outs() !== 13'b0_0000_00_010_000) begin
            errors++; $display("FAIL rst_mem_pre: got %b want %b", outs(), 13'b0_0000_00_010_000);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 13'd0 || retired !== 32'd0) begin
            errors++; $display("FAIL rst_mem_async: got %b/%0d want 0/0", outs(), retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mem_ready_hold: got %b want 0", instr_ready);
        end
        @(negedge clk);
        checks++;
        if (outs() !== IDLE || retired !== 32'd0) begin
            errors++; $display("FAIL rst_mem_fetch: got %b/%0d want %b/0", outs(), retired, IDLE);
        end
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
        send(32'h0000007F);
        @(negedge clk);
        instr_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (outs() !== 13'b0_0000_00_000_001) begin
                errors++; $display("FAIL trap_cycle%0d: got %b want %b", k, outs(), 13'b0_0000_00_000_001);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        checks++;
        if (retired !== 32'd0) begin
            errors++; $display("FAIL trap_retired: got %0d want 0", retired);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== IDLE) begin
            errors++; $display("FAIL trap_exit: got %b want %b", outs(), IDLE);
        end
`else
        send(32'h0000007F);
        checks++;
        if (outs() !== 13'b0_0000_00_000_101) begin
            errors++; $display("FAIL ill_decode: got %b want %b", outs(), 13'b0_0000_00_000_101);
        end
        @(negedge clk);
        checks++;
        if (outs() !== IDLE || retired !== 32'd1) begin
            errors++; $display("FAIL ill_fetch: got %b/%0d want %b/1", outs(), retired, IDLE);
        end
        send(32'h022081B3);
        checks++;
        if (outs() !== 13'b0_0000_00_000_101) begin
            errors++; $display("FAIL ill_funct7: got %b want %b", outs(), 13'b0_0000_00_000_101);
        end
        @(negedge clk);
        checks++;
        if (retired !== 32'd2) begin
            errors++; $display("FAIL ill_funct7_retired: got %0d want 2", retired);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        instr = '0;
        instr_valid = 1'b0;
        alu_zero = 1'b0;
        alu_lsb = 1'b0;
        mem_ack = 1'b0;
        test_reset();
        test_add();
        test_srai();
        test_load_wait();
        test_store();
        test_branch();
        test_jump_lui();
        test_reset_mid_memory();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
